// File: rtl/id_ex_stage_if.sv
// Decode/writeback/execute-side signals of the ID/EX pipeline register; no storage.
// Latency: none. Backpressure: ex_stall/flush travel down, id_stall travels back up.
interface id_ex_stage_if;
    logic        id_valid;
    logic [4:0]  id_rs_addr;
    logic [4:0]  id_rt_addr;
    logic [31:0] id_rs_data;
    logic [31:0] id_rt_data;
    logic [4:0]  id_dst_addr;
    logic [15:0] id_imm;
    logic        id_imm_sext;
    logic [3:0]  id_alu_op;
    logic        id_reg_write;
    logic        id_mem_read;
    logic        id_mem_write;
    logic        wb_reg_write;
    logic [4:0]  wb_addr;
    logic [31:0] wb_data;
    logic        ex_stall;
    logic        flush;
    logic        id_stall;
    logic        ex_valid;
    logic [4:0]  ex_rs_addr;
    logic [4:0]  ex_rt_addr;
    logic [4:0]  ex_dst_addr;
    logic [31:0] ex_rs_data;
    logic [31:0] ex_rt_data;
    logic [31:0] ex_imm32;
    logic [3:0]  ex_alu_op;
    logic        ex_reg_write;
    logic        ex_mem_read;
    logic        ex_mem_write;

    modport master (
        output id_valid, id_rs_addr, id_rt_addr, id_rs_data, id_rt_data, id_dst_addr,
               id_imm, id_imm_sext, id_alu_op, id_reg_write, id_mem_read, id_mem_write,
               wb_reg_write, wb_addr, wb_data, ex_stall, flush,
        input  id_stall, ex_valid, ex_rs_addr, ex_rt_addr, ex_dst_addr, ex_rs_data,
               ex_rt_data, ex_imm32, ex_alu_op, ex_reg_write, ex_mem_read, ex_mem_write
    );

    modport slave (
        input  id_valid, id_rs_addr, id_rt_addr, id_rs_data, id_rt_data, id_dst_addr,
               id_imm, id_imm_sext, id_alu_op, id_reg_write, id_mem_read, id_mem_write,
               wb_reg_write, wb_addr, wb_data, ex_stall, flush,
        output id_stall, ex_valid, ex_rs_addr, ex_rt_addr, ex_dst_addr, ex_rs_data,
               ex_rt_data, ex_imm32, ex_alu_op, ex_reg_write, ex_mem_read, ex_mem_write
    );
endinterface

// File: rtl/id_ex_stage.sv
// ID/EX register with writeback bypass; load-use bubble only when HAZARD_DETECT_EN is defined.
// Latency: 1 cycle decode -> ex_*. Backpressure: ex_stall holds all state, id_stall = ex_stall | load_use.
// flush beats ex_stall; a load-use hazard inserts exactly one bubble.
module id_ex_stage (
    input  logic          clk,
    input  logic          rst,
    id_ex_stage_if.slave  bus
);

    typedef struct packed {
        logic        valid;
        logic [4:0]  rs_addr;
        logic [4:0]  rt_addr;
        logic [4:0]  dst_addr;
        logic [31:0] rs_data;
        logic [31:0] rt_data;
        logic [31:0] imm32;
        logic [3:0]  alu_op;
        logic        reg_write;
        logic        mem_read;
        logic        mem_write;
    } ex_t;

    ex_t         ex_q;
    ex_t         ex_d;
    logic [31:0] rs_sel;
    logic [31:0] rt_sel;
    logic [31:0] imm_ext;
    logic        load_use;

    // Writeback lands in the register file on the same edge we capture, so bypass it here.
    always_comb begin
        rs_sel = bus.id_rs_data;
        if (bus.id_rs_addr == 5'd0)
            rs_sel = 32'd0;
        else if (bus.wb_reg_write && (bus.wb_addr == bus.id_rs_addr))
            rs_sel = bus.wb_data;

        rt_sel = bus.id_rt_data;
        if (bus.id_rt_addr == 5'd0)
            rt_sel = 32'd0;
        else if (bus.wb_reg_write && (bus.wb_addr == bus.id_rt_addr))
            rt_sel = bus.wb_data;
    end

    assign imm_ext = bus.id_imm_sext ? {{16{bus.id_imm[15]}}, bus.id_imm}
                                     : {16'd0, bus.id_imm};

`ifdef HAZARD_DETECT_EN
    assign load_use = ex_q.valid && ex_q.mem_read && (ex_q.dst_addr != 5'd0) && bus.id_valid &&
                      ((ex_q.dst_addr == bus.id_rs_addr) || (ex_q.dst_addr == bus.id_rt_addr));
`else
    assign load_use = 1'b0;
`endif

    assign bus.id_stall = bus.ex_stall | load_use;

    always_comb begin
        ex_d           = '0;
        ex_d.valid     = bus.id_valid;
        ex_d.rs_addr   = bus.id_rs_addr;
        ex_d.rt_addr   = bus.id_rt_addr;
        ex_d.dst_addr  = bus.id_dst_addr;
        ex_d.rs_data   = rs_sel;
        ex_d.rt_data   = rt_sel;
        ex_d.imm32     = imm_ext;
        ex_d.alu_op    = bus.id_alu_op;
        ex_d.reg_write = bus.id_reg_write & bus.id_valid;
        ex_d.mem_read  = bus.id_mem_read  & bus.id_valid;
        ex_d.mem_write = bus.id_mem_write & bus.id_valid;
    end

    always_ff @(posedge clk) begin
        if (!rst)
            ex_q <= '0;
        else if (bus.flush)
            ex_q <= '0;
        else if (bus.ex_stall)
            ex_q <= ex_q;
        else if (load_use)
            ex_q <= '0;
        else
            ex_q <= ex_d;
    end

    assign bus.ex_valid     = ex_q.valid;
    assign bus.ex_rs_addr   = ex_q.rs_addr;
    assign bus.ex_rt_addr   = ex_q.rt_addr;
    assign bus.ex_dst_addr  = ex_q.dst_addr;
    assign bus.ex_rs_data   = ex_q.rs_data;
    assign bus.ex_rt_data   = ex_q.rt_data;
    assign bus.ex_imm32     = ex_q.imm32;
    assign bus.ex_alu_op    = ex_q.alu_op;
    assign bus.ex_reg_write = ex_q.reg_write;
    assign bus.ex_mem_read  = ex_q.mem_read;
    assign bus.ex_mem_write = ex_q.mem_write;

endmodule

// File: tb/tb_id_ex_stage.sv
// Randomized bench for id_ex_stage against a behavioural model of the pipeline register.
module tb_id_ex_stage;

`ifdef HAZARD_DETECT_EN
    localparam logic HZ = 1'b1;
`else
    localparam logic HZ = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    id_ex_stage_if bus ();

    id_ex_stage dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic        valid;
        logic [4:0]  rs_a, rt_a, dst;
        logic [31:0] rs_d, rt_d, imm;
        logic [3:0]  op;
        logic        rw, mr, mw;
    } ex_t;

    ex_t exp_s;
    int  total = 0;
    int  bad   = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
        total++;
        if (obs !== want) begin
            bad++;
            $display("FAIL %s got=%h want=%h t=%0t", tag, obs, want, $time);
        end
    endtask

    function automatic ex_t zero_ex();
        ex_t z;
        z.valid = 0; z.rs_a = 0; z.rt_a = 0; z.dst = 0;
        z.rs_d = 0; z.rt_d = 0; z.imm = 0; z.op = 0;
        z.rw = 0; z.mr = 0; z.mw = 0;
        return z;
    endfunction

    // Value an instruction reads for a source register in this cycle.
    function automatic logic [31:0] operand(input logic [4:0] a, input logic [31:0] rf);
        if (a == 0) return 32'd0;
        if (bus.wb_reg_write && bus.wb_addr == a) return bus.wb_data;
        return rf;
    endfunction

    function automatic logic model_load_use();
        if (!HZ) return 1'b0;
        return exp_s.valid && exp_s.mr && exp_s.dst != 0 && bus.id_valid &&
               (exp_s.dst == bus.id_rs_addr || exp_s.dst == bus.id_rt_addr);
    endfunction

    function automatic ex_t model_next();
        ex_t n;
        int  s;
        if (!rst || bus.flush) return zero_ex();
        if (bus.ex_stall) return exp_s;
        if (model_load_use()) return zero_ex();
        n.valid = bus.id_valid;
        n.rs_a  = bus.id_rs_addr;
        n.rt_a  = bus.id_rt_addr;
        n.dst   = bus.id_dst_addr;
        n.rs_d  = operand(bus.id_rs_addr, bus.id_rs_data);
        n.rt_d  = operand(bus.id_rt_addr, bus.id_rt_data);
        s = int'(bus.id_imm);
        if (bus.id_imm_sext && s >= 32768) s = s - 65536;
        n.imm   = 32'(s);
        n.op    = bus.id_alu_op;
        n.rw    = bus.id_reg_write && bus.id_valid;
        n.mr    = bus.id_mem_read  && bus.id_valid;
        n.mw    = bus.id_mem_write && bus.id_valid;
        return n;
    endfunction

    task automatic check_outputs();
        chk("ex_valid",     bus.ex_valid,     exp_s.valid);
        chk("ex_rs_addr",   bus.ex_rs_addr,   exp_s.rs_a);
        chk("ex_rt_addr",   bus.ex_rt_addr,   exp_s.rt_a);
        chk("ex_dst_addr",  bus.ex_dst_addr,  exp_s.dst);
        chk("ex_rs_data",   bus.ex_rs_data,   exp_s.rs_d);
        chk("ex_rt_data",   bus.ex_rt_data,   exp_s.rt_d);
        chk("ex_imm32",     bus.ex_imm32,     exp_s.imm);
        chk("ex_alu_op",    bus.ex_alu_op,    exp_s.op);
        chk("ex_reg_write", bus.ex_reg_write, exp_s.rw);
        chk("ex_mem_read",  bus.ex_mem_read,  exp_s.mr);
        chk("ex_mem_write", bus.ex_mem_write, exp_s.mw);
    endtask

    // Inputs are set at a falling edge; compare stall, advance the model, compare registers.
    task automatic step(input bit chk_comb);
        ex_t nx;
        #1;
        if (chk_comb) chk("id_stall", bus.id_stall, bus.ex_stall | model_load_use());
        nx = model_next();
        @(posedge clk);
        #1;
        exp_s = nx;
        check_outputs();
        @(negedge clk);
    endtask

    task automatic set_idle();
        rst = 1'b1;
        bus.id_valid = 0; bus.id_rs_addr = 0; bus.id_rt_addr = 0;
        bus.id_rs_data = 0; bus.id_rt_data = 0; bus.id_dst_addr = 0;
        bus.id_imm = 0; bus.id_imm_sext = 0; bus.id_alu_op = 0;
        bus.id_reg_write = 0; bus.id_mem_read = 0; bus.id_mem_write = 0;
        bus.wb_reg_write = 0; bus.wb_addr = 0; bus.wb_data = 0;
        bus.ex_stall = 0; bus.flush = 0;
    endtask

    task automatic randomize_inputs();
        rst              = ($urandom_range(0, 29) != 0);
        bus.id_valid     = ($urandom_range(0, 4) != 0);
        bus.id_rs_addr   = 5'($urandom_range(0, 7));
        bus.id_rt_addr   = 5'($urandom_range(0, 7));
        bus.id_rs_data   = $urandom;
        bus.id_rt_data   = $urandom;
        bus.id_dst_addr  = 5'($urandom_range(0, 7));
        bus.id_imm       = 16'($urandom);
        bus.id_imm_sext  = 1'($urandom);
        bus.id_alu_op    = 4'($urandom);
        bus.id_reg_write = 1'($urandom);
        bus.id_mem_read  = ($urandom_range(0, 2) == 0);
        bus.id_mem_write = ($urandom_range(0, 3) == 0);
        bus.wb_reg_write = 1'($urandom);
        bus.wb_addr      = 5'($urandom_range(0, 7));
        bus.wb_data      = $urandom;
        bus.ex_stall     = ($urandom_range(0, 5) == 0);
        bus.flush        = ($urandom_range(0, 9) == 0);
    endtask

    initial begin
        exp_s = zero_ex();

        // Reset with everything else busy; first edge is unchecked because the DUT starts X.
        randomize_inputs();
        rst = 1'b0;
        bus.ex_stall = 1'b1;
        bus.id_valid = 1'b1;
        bus.id_mem_read = 1'b1;
        #1;
        @(posedge clk);
        @(negedge clk);
        step(1'b1);
        chk("rst_stall_eq_ex_stall", bus.id_stall, bus.ex_stall);
        bus.ex_stall = 1'b0;
        #1;
        chk("rst_stall_low", bus.id_stall, 1'b0);
        @(negedge clk);

        // Writeback bypass, then $0 never bypassed.
        set_idle();
        bus.id_valid = 1; bus.id_rs_addr = 5; bus.id_rs_data = 32'h1111;
        bus.wb_reg_write = 1; bus.wb_addr = 5; bus.wb_data = 32'hABCD;
        step(1'b1);
        chk("bypass_rs", bus.ex_rs_data, 32'hABCD);
        bus.id_rs_addr = 0; bus.wb_addr = 0; bus.id_rs_data = 32'h1111;
        step(1'b1);
        chk("bypass_r0", bus.ex_rs_data, 32'h0);
        bus.id_rs_addr = 3; bus.wb_addr = 4; bus.id_rs_data = 32'h2222;
        step(1'b1);
        chk("bypass_miss", bus.ex_rs_data, 32'h2222);

        // Immediate extension.
        set_idle();
        bus.id_valid = 1; bus.id_imm = 16'h8001; bus.id_imm_sext = 1;
        step(1'b1);
        chk("imm_sext", bus.ex_imm32, 32'hFFFF8001);
        bus.id_imm_sext = 0;
        step(1'b1);
        chk("imm_zext", bus.ex_imm32, 32'h00008001);

        // Load to $8 followed by a consumer of $8.
        set_idle();
        bus.id_valid = 1; bus.id_mem_read = 1; bus.id_reg_write = 1;
        bus.id_dst_addr = 8; bus.id_rs_addr = 2;
        step(1'b1);
        bus.id_mem_read = 0; bus.id_rt_addr = 8; bus.id_dst_addr = 9; bus.id_alu_op = 4'h3;
        #1;
        chk("lu_stall", bus.id_stall, HZ);
        step(1'b1);
        chk("lu_bubble_valid", bus.ex_valid, !HZ);
        #1;
        chk("lu_release", bus.id_stall, 1'b0);
        step(1'b1);
        chk("lu_captured", bus.ex_valid, 1'b1);
        chk("lu_captured_dst", bus.ex_dst_addr, 5'd9);

        // Three stalled cycles with changing inputs, then flush during stall.
        for (int i = 0; i < 3; i++) begin
            bus.ex_stall = 1;
            bus.id_rs_data = $urandom; bus.id_dst_addr = 5'(i + 1);
            #1;
            chk("stall_id_stall", bus.id_stall, 1'b1);
            step(1'b1);
            chk("stall_frozen_dst", bus.ex_dst_addr, 5'd9);
        end
        bus.flush = 1;
        step(1'b1);
        chk("flush_valid", bus.ex_valid, 1'b0);
        chk("flush_reg_write", bus.ex_reg_write, 1'b0);

        // Invalid decode slot must not leak control bits.
        set_idle();
        bus.id_valid = 0; bus.id_reg_write = 1; bus.id_mem_write = 1;
        step(1'b1);
        chk("inv_reg_write", bus.ex_reg_write, 1'b0);
        chk("inv_mem_write", bus.ex_mem_write, 1'b0);
        chk("inv_valid", bus.ex_valid, 1'b0);

        for (int n = 0; n < 500; n++) begin
            randomize_inputs();
            step(1'b1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/id_ex_stage.md
# id_ex_stage

Decode-to-execute pipeline register for the five-stage MIPS core. It captures the two operands read from the register file plus the decoded control and immediate fields, and bypasses a same-edge writeback so a read-after-write across the register file never returns stale data. It also detects load-use hazards, inserts one bubble and stalls decode. It sits directly downstream of the register file's read ports and upstream of the ALU/forwarding logic.

## Interface
- No parameters; data width fixed at 32, register address width at 5.
- clk  in  1  rising-edge clock
- rst  in  1  synchronous reset, active-low (asserted when 0)
- id_valid  in  1  decode slot holds a real instruction
- id_rs_addr, id_rt_addr  in  5 each  source addresses driven to the register file
- id_rs_data, id_rt_data  in  32 each  register file read data (reg_out_1/reg_out_2)
- id_dst_addr  in  5  destination register
- id_imm  in  16  raw immediate
- id_imm_sext  in  1  1 = sign-extend, 0 = zero-extend
- id_alu_op  in  4  ALU operation code
- id_reg_write, id_mem_read, id_mem_write  in  1 each  control bits
- wb_reg_write, wb_addr, wb_data  in  1/5/32  writeback port, same signals that drive the register file write port
- ex_stall  in  1  execute stage cannot accept; hold all outputs
- flush  in  1  kill the instruction entering execute
- id_stall  out  1  decode and fetch must hold this cycle
- ex_valid  out  1  execute slot valid
- ex_rs_addr, ex_rt_addr, ex_dst_addr  out  5 each
- ex_rs_data, ex_rt_data, ex_imm32  out  32 each
- ex_alu_op  out  4
- ex_reg_write, ex_mem_read, ex_mem_write  out  1 each

## Operation
- Operand select (combinational, per source): address 0 -> 32'd0; else wb_reg_write & wb_addr==address & wb_addr!=0 -> wb_data; else register file data.
- Immediate: ex_imm32 = id_imm_sext ? {{16{id_imm[15]}}, id_imm} : {16'd0, id_imm}.
- Load-use hazard (combinational): ex_valid & ex_mem_read & ex_dst_addr!=0 & id_valid & (ex_dst_addr==id_rs_addr | ex_dst_addr==id_rt_addr).
- id_stall = ex_stall | load_use.
- Register update each rising edge, priority highest first:
  - rst==0: all outputs registered to 0.
  - flush: bubble (all registered outputs 0), even if ex_stall=1.
  - ex_stall: hold every output unchanged.
  - load_use: bubble.
  - otherwise: capture selected operands, ex_imm32, addresses, alu_op; ex_valid=id_valid; control bits = id_* AND id_valid.
- Bubble: ex_valid, controls, addresses, data, imm, alu_op all 0.

## Timing
- Latency: one cycle from decode inputs to ex_* outputs.
- id_stall is combinational from registered state and current inputs; asserted in the same cycle as the hazard.
- Load-use stall lasts exactly one cycle: the bubble clears ex_mem_read, so the next cycle captures normally, with the load result arriving through the writeback bypass or downstream forwarding.
- Reset mid-stall or mid-hazard: outputs 0 the next edge, id_stall then depends only on ex_stall.
- Simultaneous flush and load_use: flush wins (result identical, bubble). Simultaneous flush and ex_stall: flush wins.
- Writeback to $0 is never bypassed; a same-cycle writeback to a non-matching address is ignored.

## Configuration
- HAZARD_DETECT_EN defined: load-use detection, bubble insertion and the load_use term of id_stall as above.
- Undefined: load_use is constant 0, id_stall = ex_stall, no bubbles inserted; software scheduling must cover load delay slots. All other behaviour is identical.

## Test plan
- Reset: drive rst=0 for 2 cycles with all inputs nonzero -> every output 0, id_stall = ex_stall.
- Bypass: id_rs_addr=5, id_rs_data=32'h1111, wb_reg_write=1, wb_addr=5, wb_data=32'hABCD -> next cycle ex_rs_data=32'hABCD. Repeat with wb_addr=0, id_rs_addr=0 -> ex_rs_data=0.
- Immediate: id_imm=16'h8001, sext=1 -> ex_imm32=32'hFFFF8001; sext=0 -> 32'h00008001.
- Load-use (macro on): lw to $8 captured, next decode reads rt=$8 -> id_stall=1 for one cycle, ex_valid=0 next, then the instruction is captured with id_stall=0. Macro off -> no stall, captured immediately.
- Stall/flush: ex_stall=1 for 3 cycles -> outputs frozen, id_stall=1; flush=1 with ex_stall=1 -> ex_valid=0 and ex_reg_write=0 next cycle.
- Invalid decode: id_valid=0 with id_reg_write=1, id_mem_write=1 -> ex_reg_write=0, ex_mem_write=0, ex_valid=0.
